// File: rtl/pipelined_adder_tree.sv
// Pipelined adder tree over 2**N_STAGE lanes feeding a saturating accumulator.
// A valid bit and an acc_en bit travel alongside each sample through the tree.
module pipelined_adder_tree #(
   parameter  int unsigned N_STAGE = 5,
   parameter  int unsigned IN_W    = 2,
   parameter  int unsigned SIGNED  = 0,
   parameter  int unsigned PIPE    = 1,
   parameter  int unsigned ACC_W   = 16,
   localparam int unsigned L       = 1 << N_STAGE,
   localparam int unsigned OUT_W   = IN_W + N_STAGE
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   input  logic [L*IN_W-1:0]  x,
   input  logic               acc_en,
   input  logic               acc_clr,
   output logic               sum_valid,
   output logic [OUT_W-1:0]   sum,
   output logic [ACC_W-1:0]   acc,
   output logic               acc_sat
);

   localparam bit SX = (SIGNED != 0);

   for (genvar s = 0; s <= N_STAGE; s++) begin : g_stg
      localparam int unsigned W = IN_W + s;
      localparam int unsigned N = L >> s;

      logic [W-1:0] w_node [N];
      logic         w_v;
      logic         w_e;

      if (s == 0) begin : g_in
         for (genvar k = 0; k < N; k++) begin : g_lane
            assign w_node[k] = x[k*IN_W +: IN_W];
         end
         assign w_v = in_valid;
         assign w_e = acc_en;
      end else begin : g_add
         logic [W-1:0] w_add [N];

         for (genvar k = 0; k < N; k++) begin : g_pair
            logic [W-2:0] w_a;
            logic [W-2:0] w_b;
            assign w_a      = g_stg[s-1].w_node[2*k];
            assign w_b      = g_stg[s-1].w_node[2*k+1];
            assign w_add[k] = {SX & w_a[W-2], w_a} + {SX & w_b[W-2], w_b};
         end

         // The final stage is always registered so sum/sum_valid are flop outputs.
         if (PIPE != 0 || s == N_STAGE) begin : g_reg
            logic [W-1:0] r_node [N];
            logic         r_v;
            logic         r_e;

            // Data only loads on a valid sample, so bubbles hold the last value.
            always_ff @(posedge clk) begin
               if (reset) begin
                  r_v    <= 1'b0;
                  r_e    <= 1'b0;
                  r_node <= '{default: '0};
               end else begin
                  r_v <= g_stg[s-1].w_v;
                  r_e <= g_stg[s-1].w_e;
                  if (g_stg[s-1].w_v) r_node <= w_add;
               end
            end

            assign w_node = r_node;
            assign w_v    = r_v;
            assign w_e    = r_e;
         end else begin : g_comb
            assign w_node = w_add;
            assign w_v    = g_stg[s-1].w_v;
            assign w_e    = g_stg[s-1].w_e;
         end
      end
   end

   logic              w_out_en;
   logic              w_add_now;
   logic [ACC_W:0]    w_sum_x;
   logic [ACC_W:0]    w_acc_x;
   logic [ACC_W:0]    w_tot;
   logic [ACC_W-1:0]  w_acc_nxt;
   logic              w_sat_nxt;
   logic [ACC_W-1:0]  r_acc;
   logic              r_sat;

   assign sum_valid = g_stg[N_STAGE].w_v;
   assign sum       = g_stg[N_STAGE].w_node[0];
   assign w_out_en  = g_stg[N_STAGE].w_e;
   assign w_add_now = sum_valid & w_out_en;

   // One guard bit above ACC_W makes the add exact; clipping looks at it.
   assign w_sum_x = {{(ACC_W + 1 - OUT_W){SX & sum[OUT_W-1]}}, sum};
   assign w_acc_x = {SX & r_acc[ACC_W-1], r_acc};
   assign w_tot   = w_acc_x + w_sum_x;

   always_comb begin
      w_acc_nxt = r_acc;
      w_sat_nxt = r_sat;
      if (acc_clr) begin
         w_acc_nxt = w_add_now ? w_sum_x[ACC_W-1:0] : '0;
         w_sat_nxt = 1'b0;
      end else if (w_add_now) begin
         if (!SX && w_tot[ACC_W]) begin
            w_acc_nxt = '1;
            w_sat_nxt = 1'b1;
         end else if (SX && (w_tot[ACC_W] != w_tot[ACC_W-1])) begin
            w_acc_nxt = w_tot[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                     : {1'b0, {(ACC_W-1){1'b1}}};
            w_sat_nxt = 1'b1;
         end else begin
            w_acc_nxt = w_tot[ACC_W-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_acc <= '0;
         r_sat <= 1'b0;
      end else begin
         r_acc <= w_acc_nxt;
         r_sat <= w_sat_nxt;
      end
   end

   assign acc     = r_acc;
   assign acc_sat = r_sat;

endmodule

// File: tb/tb_pipelined_adder_tree.sv
// Directed bench: four tree configurations share one stimulus stream,
// each output checked against hand-computed values.
module tb_pipelined_adder_tree;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic [63:0] x;
   logic        acc_en;
   logic        acc_clr;

   logic        sv_a, sv_b, sv_c, sv_d;
   logic [6:0]  sum_a, sum_b, sum_c, sum_d;
   logic [15:0] acc_a, acc_b, acc_c;
   logic [7:0]  acc_d;
   logic        sat_a, sat_b, sat_c, sat_d;

   int n_chk  = 0;
   int n_pass = 0;

   // a: defaults, b: signed piped, c: signed combinational, d: 8-bit accumulator
   pipelined_adder_tree u_a (
      .clk(clk), .reset(reset), .in_valid(in_valid), .x(x), .acc_en(acc_en),
      .acc_clr(acc_clr), .sum_valid(sv_a), .sum(sum_a), .acc(acc_a), .acc_sat(sat_a));
   pipelined_adder_tree #(.SIGNED(1)) u_b (
      .clk(clk), .reset(reset), .in_valid(in_valid), .x(x), .acc_en(acc_en),
      .acc_clr(acc_clr), .sum_valid(sv_b), .sum(sum_b), .acc(acc_b), .acc_sat(sat_b));
   pipelined_adder_tree #(.SIGNED(1), .PIPE(0)) u_c (
      .clk(clk), .reset(reset), .in_valid(in_valid), .x(x), .acc_en(acc_en),
      .acc_clr(acc_clr), .sum_valid(sv_c), .sum(sum_c), .acc(acc_c), .acc_sat(sat_c));
   pipelined_adder_tree #(.ACC_W(8)) u_d (
      .clk(clk), .reset(reset), .in_valid(in_valid), .x(x), .acc_en(acc_en),
      .acc_clr(acc_clr), .sum_valid(sv_d), .sum(sum_d), .acc(acc_d), .acc_sat(sat_d));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic idle();
      in_valid = 1'b0;
      acc_en   = 1'b0;
      x        = {$urandom, $urandom};
   endtask

   // Single-sample pulse: unsigned result on a, signed result on b and c.
   task automatic run_pulse(input string tag, input logic [63:0] xv,
                            input logic [6:0] exp_u, input logic [6:0] exp_s);
      x        = xv;
      in_valid = 1'b1;
      acc_en   = 1'b0;
      step();
      idle();
      for (int k = 1; k <= 6; k++) begin
         check({tag, "_a_vld"}, 32'(sv_a), 32'(k == 5));
         check({tag, "_b_vld"}, 32'(sv_b), 32'(k == 5));
         check({tag, "_c_vld"}, 32'(sv_c), 32'(k == 1));
         if (k == 1) check({tag, "_c_sum"}, 32'(sum_c), 32'(exp_s));
         if (k == 5) begin
            check({tag, "_a_sum"}, 32'(sum_a), 32'(exp_u));
            check({tag, "_b_sum"}, 32'(sum_b), 32'(exp_s));
         end
         if (k == 6) begin
            check({tag, "_a_hold"}, 32'(sum_a), 32'(exp_u));
            check({tag, "_a_acc"},  32'(acc_a), 32'd0);
         end
         step();
      end
   endtask

   logic       str_v   [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
   logic [1:0] str_l0  [4] = '{2'd1, 2'd2, 2'd0, 2'd3};
   logic [6:0] str_sum [4] = '{7'd1, 7'd2, 7'd2, 7'd3};

   initial begin
      int seen;
      reset   = 1'b1;
      acc_clr = 1'b0;
      idle();
      step();
      step();
      check("rst_a_vld", 32'(sv_a), 32'd0);
      check("rst_a_sum", 32'(sum_a), 32'd0);
      check("rst_a_acc", 32'(acc_a), 32'd0);
      check("rst_a_sat", 32'(sat_a), 32'd0);
      check("rst_c_vld", 32'(sv_c), 32'd0);
      reset = 1'b0;
      step();

      // all 3s: 96 unsigned, -32 signed; 10s: 64 / -64; 01s: 32; alternating 1,-1: 64 / 0
      run_pulse("max", {32{2'b11}}, 7'd96, 7'h60);
      run_pulse("neg", {32{2'b10}}, 7'd64, 7'h40);
      run_pulse("pos", {32{2'b01}}, 7'd32, 7'h20);
      run_pulse("alt", {16{4'b1101}}, 7'd64, 7'h00);

      // streaming with a bubble: lane 0 only
      for (int k = 1; k <= 10; k++) begin
         if (k <= 4) begin
            in_valid = str_v[k-1];
            acc_en   = 1'b0;
            x        = str_v[k-1] ? 64'(str_l0[k-1]) : {$urandom, $urandom};
         end else idle();
         step();
         check("str_vld", 32'(sv_a), 32'((k >= 5 && k <= 8) ? str_v[k-5] : 1'b0));
         if (k >= 5 && k <= 8) check("str_sum", 32'(sum_a), 32'(str_sum[k-5]));
      end

      // accumulate three 96s; the 8-bit accumulator clips on the third
      for (int k = 1; k <= 8; k++) begin
         if (k <= 3) begin
            in_valid = 1'b1;
            acc_en   = 1'b1;
            x        = '1;
         end else idle();
         step();
         if (k == 4) check("acc_c_neg", 32'(acc_c), 32'h0000_FFA0);
         if (k == 6) begin
            check("acc_d_96",  32'(acc_d), 32'd96);
            check("acc_d_s0",  32'(sat_d), 32'd0);
         end
         if (k == 7) begin
            check("acc_d_192", 32'(acc_d), 32'd192);
            check("acc_d_s1",  32'(sat_d), 32'd0);
         end
         if (k == 8) begin
            check("acc_d_255", 32'(acc_d), 32'd255);
            check("acc_d_sat", 32'(sat_d), 32'd1);
            check("acc_a_288", 32'(acc_a), 32'd288);
            check("acc_a_sat", 32'(sat_a), 32'd0);
            check("acc_b_neg", 32'(acc_b), 32'h0000_FFA0);
         end
      end
      acc_clr = 1'b1;
      step();
      acc_clr = 1'b0;
      check("clr_d_acc", 32'(acc_d), 32'd0);
      check("clr_d_sat", 32'(sat_d), 32'd0);
      check("clr_a_acc", 32'(acc_a), 32'd0);

      // acc reaches 50, then clear lands in the cycle a 96 emerges
      for (int k = 1; k <= 7; k++) begin
         if (k == 1) begin
            in_valid = 1'b1;
            acc_en   = 1'b1;
            x        = 64'h0000_0002_FFFF_FFFF;
         end else if (k == 2) begin
            in_valid = 1'b1;
            acc_en   = 1'b1;
            x        = '1;
         end else idle();
         acc_clr = (k == 7);
         step();
         if (k == 6) check("cc_d_50", 32'(acc_d), 32'd50);
         if (k == 7) begin
            check("cc_d_96", 32'(acc_d), 32'd96);
            check("cc_a_96", 32'(acc_a), 32'd96);
         end
      end
      acc_clr = 1'b0;

      // reset with three samples in flight
      for (int k = 1; k <= 3; k++) begin
         in_valid = 1'b1;
         acc_en   = 1'b1;
         x        = '1;
         step();
      end
      idle();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("mr_a_vld", 32'(sv_a), 32'd0);
      check("mr_a_sum", 32'(sum_a), 32'd0);
      check("mr_a_acc", 32'(acc_a), 32'd0);
      check("mr_c_acc", 32'(acc_c), 32'd0);
      check("mr_d_sum", 32'(sum_d), 32'd0);
      seen = 0;
      for (int k = 1; k <= 6; k++) begin
         step();
         seen += int'(sv_a);
      end
      check("mr_drop", 32'(seen), 32'd0);
      x        = 64'd1;
      in_valid = 1'b1;
      step();
      idle();
      for (int k = 1; k <= 5; k++) begin
         check("mr_new_vld", 32'(sv_a), 32'(k == 5));
         if (k == 5) check("mr_new_sum", 32'(sum_a), 32'd1);
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
